// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a one-entry output register towards decode.
//   A byte PC addresses a combinational instruction memory. Each accepted
//   slot captures one instruction. An out-of-range fetch is replaced by
//   NOP_INST with id_fault set, and the stage halts. An ecall or ebreak word
//   is delivered normally and then halts the stage. A redirect overrides
//   everything: it restarts fetching at the new target and flushes the
//   output register.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   imem_addr      out  [31:0] word index into instruction memory (pc >> 2)
//   imem_inst      in   [31:0] combinational read data for imem_addr
//   redirect_valid in   branch/jump redirect request
//   redirect_pc    in   [31:0] redirect byte target (bits [1:0] ignored)
//   id_ready       in   decode accepts id_* this cycle
//   id_valid       out  id_* hold a valid fetched instruction
//   id_inst        out  [31:0] registered instruction
//   id_pc          out  [31:0] byte PC of id_inst
//   id_fault       out  id_inst is NOP_INST substituted for an out-of-range fetch
//   fetch_halted   out  stage is in HALT
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 10,
    parameter logic [31:0] NOP_INST  = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_fault,
    output logic        fetch_halted
);

    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [29:0] MEM_LIMIT   = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_fault_q, id_fault_d;

    logic slot_free;
    logic in_range;
    logic is_stop_inst;

    assign slot_free    = !id_valid_q || id_ready;
    assign in_range     = pc_q[31:2] < MEM_LIMIT;
    assign is_stop_inst = (imem_inst == ECALL_INST) || (imem_inst == EBREAK_INST);

    // NOTE: every signal driven here gets a hold default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_fault_d = id_fault_q;

        if (redirect_valid) begin
            // Redirect wins in every state: restart at the aligned target and
            // drop whatever sits in the output register, accepted or not.
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            id_fault_d = 1'b0;
            state_d    = FETCH;
        end else begin
            unique case (state_q)
                START: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    // With the slot occupied and not accepted, everything
                    // holds, so the stalled word is offered again next cycle.
                    if (slot_free) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_q;
                        if (!in_range) begin
                            // pc holds so imem_addr keeps pointing at the
                            // faulting word while halted.
                            id_inst_d  = NOP_INST;
                            id_fault_d = 1'b1;
                            state_d    = HALT;
                        end else begin
                            id_inst_d  = imem_inst;
                            id_fault_d = 1'b0;
                            pc_d       = pc_q + 32'd4;
                            if (is_stop_inst) begin
                                state_d = HALT;
                            end
                        end
                    end
                end
                HALT: begin
                    // Drain the last word once decode takes it.
                    if (id_ready) begin
                        id_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = START;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= 32'h0;
            id_pc_q    <= 32'h0;
            id_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_fault_q <= id_fault_d;
        end
    end

    assign imem_addr    = {2'b00, pc_q[31:2]};
    assign id_valid     = id_valid_q;
    assign id_inst      = id_inst_q;
    assign id_pc        = id_pc_q;
    assign id_fault     = id_fault_q;
    assign fetch_halted = (state_q == HALT);

endmodule
